// File: rtl/mpu9250_sample_assembler.sv
// MPU9250 sample assembler: collects 14-byte register bursts into a word bank, served over AXI-Lite reads.
// Optional feature: define MPU9250_SAMPLE_TIMESTAMP_EN to capture a free-running cycle count at each commit (word 5).
module mpu9250_sample_assembler #(
    parameter int BURST_LEN = 14,
    parameter int ERR_CNT_W = 8
) (
    input  logic        s00_axi_aclk,
    input  logic        s00_axi_areset,
    input  logic        clk_en,
    input  logic        rx_burst_start,
    input  logic        rx_byte_valid,
    input  logic [7:0]  rx_byte,
    input  logic        rx_burst_done,
    input  logic        rx_nack,
    input  logic        s00_axi_arvalid,
    input  logic [2:0]  s00_axi_araddr,
    output logic        s00_axi_arready,
    output logic        s00_axi_rvalid,
    output logic [31:0] s00_axi_rdata,
    output logic [1:0]  s00_axi_rresp,
    input  logic        s00_axi_rready,
    output logic        data_ready
);
    // Read channel: AR accepted when arvalid && arready; arready is held low while rvalid is high,
    // so at most one read is outstanding and rdata stays stable until rvalid && rready.
    localparam int IDX_W = $clog2(BURST_LEN + 1);
    localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(BURST_LEN);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FAIL    = 2'd2
    } state_t;

    state_t                 state, state_nx;
    logic [IDX_W-1:0]       idx, idx_nx;
    logic [7:0]             shadow [BURST_LEN];
    logic [7:0]             sh_eff [BURST_LEN];
    logic                   byte_wr, commit, error;
    logic [15:0]            words [7];
    logic [15:0]            sample_count;
    logic [ERR_CNT_W-1:0]   err_count;
    logic                   new_sample, last_err;
    logic                   ar_hs, rd_status;
    logic [31:0]            status, bank_data;
    logic [1:0]             bank_resp;
`ifdef MPU9250_SAMPLE_TIMESTAMP_EN
    logic [31:0]            ts_cnt, ts_cap;
`endif

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        byte_wr  = 1'b0;
        commit   = 1'b0;
        error    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_burst_start) begin
                    state_nx = ST_COLLECT;
                    idx_nx   = '0;
                end
            end
            ST_COLLECT: begin
                if (rx_burst_start) begin
                    error  = 1'b1;
                    idx_nx = '0;
                end else if (rx_nack) begin
                    state_nx = rx_burst_done ? ST_IDLE : ST_FAIL;
                    error    = rx_burst_done;
                end else if (rx_byte_valid && idx == FULL_IDX) begin
                    state_nx = rx_burst_done ? ST_IDLE : ST_FAIL;
                    error    = rx_burst_done;
                end else begin
                    // A byte arriving with done is stored first, then the count is judged.
                    if (rx_byte_valid) begin
                        byte_wr = 1'b1;
                        idx_nx  = idx + 1'b1;
                    end
                    if (rx_burst_done) begin
                        state_nx = ST_IDLE;
                        commit   = (idx_nx == FULL_IDX);
                        error    = (idx_nx != FULL_IDX);
                    end
                end
            end
            ST_FAIL: begin
                if (rx_burst_start) begin
                    error    = 1'b1;
                    state_nx = ST_COLLECT;
                    idx_nx   = '0;
                end else if (rx_burst_done) begin
                    error    = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        sh_eff = shadow;
        if (byte_wr) sh_eff[idx] = rx_byte;
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else if (clk_en) begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (clk_en) shadow <= sh_eff;
    end

    assign ar_hs     = s00_axi_arvalid && s00_axi_arready;
    assign rd_status = ar_hs && (s00_axi_araddr == 3'd4);

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            for (int k = 0; k < 7; k++) words[k] <= '0;
            sample_count <= '0;
            err_count    <= '0;
            new_sample   <= 1'b0;
            last_err     <= 1'b0;
            data_ready   <= 1'b0;
        end else if (clk_en) begin
            data_ready <= commit;
            if (commit) begin
                for (int k = 0; k < 7; k++) words[k] <= {sh_eff[2*k], sh_eff[2*k+1]};
                sample_count <= sample_count + 16'd1;
            end
            if (error && err_count != '1) err_count <= err_count + 1'b1;
            // A flag set in the same cycle as the status read wins over the clear.
            if (commit)         new_sample <= 1'b1;
            else if (rd_status) new_sample <= 1'b0;
            if (error)          last_err <= 1'b1;
            else if (rd_status) last_err <= 1'b0;
        end
    end

`ifdef MPU9250_SAMPLE_TIMESTAMP_EN
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            ts_cnt <= '0;
            ts_cap <= '0;
        end else if (clk_en) begin
            ts_cnt <= ts_cnt + 32'd1;
            if (commit) ts_cap <= ts_cnt;
        end
    end
`endif

    always_comb begin
        status             = '0;
        status[0]          = new_sample;
        status[1]          = last_err;
        status[8 +: ERR_CNT_W] = err_count;
        status[16 +: IDX_W]    = idx;
        status[21:20]      = state;
        bank_data          = '0;
        bank_resp          = 2'b00;
        case (s00_axi_araddr)
            3'd0: bank_data = {words[1], words[0]};
            3'd1: bank_data = {words[4], words[2]};
            3'd2: bank_data = {words[6], words[5]};
            3'd3: bank_data = {sample_count, words[3]};
            3'd4: bank_data = status;
`ifdef MPU9250_SAMPLE_TIMESTAMP_EN
            3'd5: bank_data = ts_cap;
`endif
            default: bank_resp = 2'b10;
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= '0;
            s00_axi_rresp   <= 2'b00;
        end else if (clk_en) begin
            if (ar_hs) begin
                s00_axi_rvalid  <= 1'b1;
                s00_axi_arready <= 1'b0;
                s00_axi_rdata   <= bank_data;
                s00_axi_rresp   <= bank_resp;
            end else if (s00_axi_rvalid && s00_axi_rready) begin
                s00_axi_rvalid  <= 1'b0;
                s00_axi_arready <= 1'b1;
            end else begin
                s00_axi_arready <= !s00_axi_rvalid;
            end
        end
    end
endmodule
